// File: rtl/fft_iter_seq.sv
`default_nettype none
// ============================================================================
//  Module   : fft_iter_seq
//  Purpose  : Address/control sequencer for an in-place radix-2 DIT FFT.
//             Issues one butterfly read per cycle, walks all AWL stages and
//             replays the read addresses as write-back addresses after the
//             butterfly pipeline latency.
//  Revision : 1.0  initial release
// ============================================================================
module fft_iter_seq #(
    parameter int AWL    = 5,
    parameter int BF_LAT = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_en,
    input  logic                       i_start,
    input  logic                       i_inv,
    output logic                       o_rd_en,
    output logic [AWL-1:0]             o_a_raddr,
    output logic [AWL-1:0]             o_b_raddr,
    output logic [AWL-2:0]             o_tw_addr,
    output logic                       o_tw_conj,
    output logic                       o_wr_en,
    output logic [AWL-1:0]             o_a_waddr,
    output logic [AWL-1:0]             o_b_waddr,
    output logic [$clog2(AWL+1)-1:0]   o_stage,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_ram_block
);

    localparam int SW  = $clog2(AWL + 1);
    localparam int DW  = $clog2(BF_LAT + 1);
    localparam int DLW = 2 * AWL + 1;

    localparam logic [AWL-1:0] c_half       = AWL'(1) << (AWL - 1);
    localparam logic [SW-1:0]  c_last_stage = SW'(AWL - 1);
    localparam logic [DW-1:0]  c_last_drain = DW'(BF_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    // r_bfly is the index of the next butterfly to issue, so the registered
    // read addresses trail it by one cycle.
    logic [SW-1:0]       r_s;
    logic [AWL-1:0]      r_bfly;
    logic [DW-1:0]       r_d;
    logic                r_inv;
    logic                r_rd_en;
    logic [AWL-1:0]      r_a_raddr;
    logic [AWL-1:0]      r_b_raddr;
    logic [AWL-2:0]      r_tw;
    logic [BF_LAT*DLW-1:0] r_dl;

    logic                w_issue;
    logic [SW-1:0]       w_s_iss;
    logic [AWL-1:0]      w_b_iss;
    logic [SW-1:0]       w_s_nxt;
    logic [AWL-1:0]      w_b_nxt;
    logic [DW-1:0]       w_d_nxt;
    logic                w_inv_nxt;

    logic [AWL-1:0]      w_span;
    logic [AWL-1:0]      w_pos;
    logic [AWL-1:0]      w_grp;
    logic [AWL-1:0]      w_a_addr;
    logic [AWL-1:0]      w_b_addr;
    logic [AWL-2:0]      w_tw;
    logic [DLW-1:0]      w_dl_in;
    logic [DLW-1:0]      w_dl_out;

    // Next-state and issue decision; a new stage's first butterfly is issued
    // on the same edge that leaves DRAIN so no idle cycle is inserted.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_s_iss     = r_s;
        w_b_iss     = r_bfly;
        w_s_nxt     = r_s;
        w_b_nxt     = r_bfly;
        w_d_nxt     = r_d;
        w_inv_nxt   = r_inv;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_RUN;
                    w_issue     = 1'b1;
                    w_s_iss     = '0;
                    w_b_iss     = '0;
                    w_s_nxt     = '0;
                    w_b_nxt     = AWL'(1);
                    w_inv_nxt   = i_inv;
                end
            end
            S_RUN: begin
                if (r_bfly == c_half) begin
                    w_state_nxt = S_DRAIN;
                    w_d_nxt     = '0;
                end else begin
                    w_issue = 1'b1;
                    w_b_nxt = r_bfly + AWL'(1);
                end
            end
            S_DRAIN: begin
                if (r_d == c_last_drain) begin
                    if (r_s == c_last_stage) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_RUN;
                        w_issue     = 1'b1;
                        w_s_iss     = r_s + SW'(1);
                        w_b_iss     = '0;
                        w_s_nxt     = r_s + SW'(1);
                        w_b_nxt     = AWL'(1);
                    end
                end else begin
                    w_d_nxt = r_d + DW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_s_nxt     = '0;
                w_b_nxt     = '0;
            end
        endcase
    end

    // DIT butterfly addressing for the butterfly about to be issued.
    always_comb begin
        w_span   = AWL'(1) << w_s_iss;
        w_pos    = w_b_iss & (w_span - AWL'(1));
        w_grp    = w_b_iss >> w_s_iss;
        w_a_addr = (w_grp << (w_s_iss + SW'(1))) | w_pos;
        w_b_addr = w_a_addr | w_span;
        w_tw     = (AWL-1)'(w_pos << (c_last_stage - w_s_iss));
    end

    // FSM, counters and registered read-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_s       <= '0;
            r_bfly    <= '0;
            r_d       <= '0;
            r_inv     <= 1'b0;
            r_rd_en   <= 1'b0;
            r_a_raddr <= '0;
            r_b_raddr <= '0;
            r_tw      <= '0;
        end else if (i_en) begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_bfly  <= w_b_nxt;
            r_d     <= w_d_nxt;
            r_inv   <= w_inv_nxt;
            r_rd_en <= w_issue;
            if (w_issue) begin
                r_a_raddr <= w_a_addr;
                r_b_raddr <= w_b_addr;
                r_tw      <= w_tw;
            end
        end
    end

    assign w_dl_in = {r_rd_en, r_a_raddr, r_b_raddr};

    // Write-back delay line: read strobe and addresses shifted BF_LAT enabled cycles.
    if (BF_LAT == 1) begin : g_dl_single
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_dl <= '0;
            end else if (i_en) begin
                r_dl <= w_dl_in;
            end
        end
    end else begin : g_dl_multi
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_dl <= '0;
            end else if (i_en) begin
                r_dl <= {r_dl[(BF_LAT-1)*DLW-1:0], w_dl_in};
            end
        end
    end

    assign w_dl_out    = r_dl[BF_LAT*DLW-1 -: DLW];

    assign o_rd_en     = r_rd_en;
    assign o_a_raddr   = r_a_raddr;
    assign o_b_raddr   = r_b_raddr;
    assign o_tw_addr   = r_tw;
    assign o_tw_conj   = r_inv;
    assign o_wr_en     = w_dl_out[DLW-1];
    assign o_a_waddr   = w_dl_out[2*AWL-1:AWL];
    assign o_b_waddr   = w_dl_out[AWL-1:0];
    assign o_stage     = r_s;
    assign o_busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign o_done      = (r_state == S_DONE);
    assign o_ram_block = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fft_iter_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fft_iter_seq
//  Purpose  : Directed, table-driven check of fft_iter_seq (AWL=3, BF_LAT=2).
//  Revision : 1.0  initial release
// ============================================================================
module tb_fft_iter_seq;

    localparam int AWL    = 3;
    localparam int BF_LAT = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_en;
    logic       i_start;
    logic       i_inv;
    logic       o_rd_en;
    logic [2:0] o_a_raddr;
    logic [2:0] o_b_raddr;
    logic [1:0] o_tw_addr;
    logic       o_tw_conj;
    logic       o_wr_en;
    logic [2:0] o_a_waddr;
    logic [2:0] o_b_waddr;
    logic [1:0] o_stage;
    logic       o_busy;
    logic       o_done;
    logic       o_ram_block;

    fft_iter_seq #(.AWL(AWL), .BF_LAT(BF_LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_en        (i_en),
        .i_start     (i_start),
        .i_inv       (i_inv),
        .o_rd_en     (o_rd_en),
        .o_a_raddr   (o_a_raddr),
        .o_b_raddr   (o_b_raddr),
        .o_tw_addr   (o_tw_addr),
        .o_tw_conj   (o_tw_conj),
        .o_wr_en     (o_wr_en),
        .o_a_waddr   (o_a_waddr),
        .o_b_waddr   (o_b_waddr),
        .o_stage     (o_stage),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_ram_block (o_ram_block)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic       rd;
        logic [2:0] a;
        logic [2:0] b;
        logic [1:0] tw;
        logic       wr;
        logic [2:0] wa;
        logic [2:0] wb;
        logic [1:0] stg;
        logic       busy;
        logic       done;
        logic       blk;
    } vec_t;

    // Row k = k-th cycle after the edge that accepts START.
    vec_t tbl [1:20];

    // Hand-computed butterfly operands per stage.
    int ra [0:2][0:3] = '{'{0, 2, 4, 6}, '{0, 1, 4, 5}, '{0, 1, 2, 3}};
    int rb [0:2][0:3] = '{'{1, 3, 5, 7}, '{2, 3, 6, 7}, '{4, 5, 6, 7}};
    int rt [0:2][0:3] = '{'{0, 0, 0, 0}, '{0, 2, 0, 2}, '{0, 1, 2, 3}};

    task automatic build_table();
        for (int k = 1; k <= 20; k++) begin
            tbl[k] = '{rd: 1'b0, a: 3'd0, b: 3'd0, tw: 2'd0, wr: 1'b0, wa: 3'd0,
                       wb: 3'd0, stg: 2'd0, busy: 1'b0, done: 1'b0, blk: 1'b0};
            tbl[k].busy = (k <= 18);
            tbl[k].done = (k == 19);
            tbl[k].blk  = (k <= 19);
            tbl[k].stg  = (k <= 6) ? 2'd0 : (k <= 12) ? 2'd1 : (k <= 19) ? 2'd2 : 2'd0;
        end
        // Each stage: 4 read cycles then 2 drain cycles; writes lag reads by 2.
        for (int s = 0; s < 3; s++) begin
            for (int b = 0; b < 4; b++) begin
                int rc;
                rc = 6 * s + 1 + b;
                tbl[rc].rd       = 1'b1;
                tbl[rc].a        = 3'(ra[s][b]);
                tbl[rc].b        = 3'(rb[s][b]);
                tbl[rc].tw       = 2'(rt[s][b]);
                tbl[rc + 2].wr   = 1'b1;
                tbl[rc + 2].wa   = 3'(ra[s][b]);
                tbl[rc + 2].wb   = 3'(rb[s][b]);
            end
        end
    endtask

    function automatic logic [21:0] pack(logic rd, logic [2:0] a, logic [2:0] b, logic [1:0] tw,
                                         logic wr, logic [2:0] wa, logic [2:0] wb, logic [1:0] stg,
                                         logic busy, logic done, logic blk, logic conj,
                                         logic rd_m, logic wr_m, logic blk_m);
        if (!rd_m) begin a = 3'd0; b = 3'd0; tw = 2'd0; end
        if (!wr_m) begin wa = 3'd0; wb = 3'd0; end
        if (!blk_m) conj = 1'b0;
        return {rd, a, b, tw, wr, wa, wb, stg, busy, done, blk, conj};
    endfunction

    task automatic check_row(input string nm, input int k, input logic conj_exp);
        logic [21:0] e_w;
        logic [21:0] a_w;
        vec_t        e;
        e   = tbl[k];
        e_w = pack(e.rd, e.a, e.b, e.tw, e.wr, e.wa, e.wb, e.stg, e.busy, e.done, e.blk,
                   conj_exp, e.rd, e.wr, e.blk);
        a_w = pack(o_rd_en, o_a_raddr, o_b_raddr, o_tw_addr, o_wr_en, o_a_waddr, o_b_waddr,
                   o_stage, o_busy, o_done, o_ram_block, o_tw_conj, e.rd, e.wr, e.blk);
        n_vec++;
        if (a_w !== e_w) begin
            n_bad++;
            $display("FAIL %s row %0d: got %h expected %h", nm, k, a_w, e_w);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [21:0] all_outs();
        return {o_rd_en, o_a_raddr, o_b_raddr, o_tw_addr, o_tw_conj, o_wr_en, o_a_waddr,
                o_b_waddr, o_stage, o_busy, o_done, o_ram_block};
    endfunction

    // Start a transform and walk the expected table cycle by cycle.
    task automatic run_seq(input string nm, input logic inv, input bit toggle, input bit hold,
                           input int freeze_at, input int abort_at,
                           output int done_cyc, output int n_wr, output int n_done);
        int cyc;
        i_inv    = inv;
        i_start  = 1'b1;
        @(posedge clk); #1;
        cyc      = 0;
        done_cyc = -1;
        n_wr     = 0;
        n_done   = 0;
        for (int k = 1; k <= 20; k++) begin
            if (!hold) i_start = 1'b0;
            if (toggle) i_inv = ~i_inv;
            check_row(nm, k, inv);
            if (o_wr_en) n_wr++;
            if (o_done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (k == abort_at) return;
            if (k == freeze_at) begin
                i_en = 1'b0;
                repeat (3) begin
                    @(posedge clk); #1;
                    cyc++;
                    check_row(nm, k, inv);
                    if (o_wr_en) n_wr++;
                end
                i_en = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, nw, nd, n2, wr_seen, blk_seen;
        build_table();

        rst = 1'b1; i_en = 1'b0; i_start = 1'b0; i_inv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 32'(all_outs()), 32'd0);
        rst = 1'b0; i_en = 1'b1;
        @(posedge clk); #1;
        chk("idle_no_start", {29'd0, o_busy, o_rd_en, o_wr_en}, 32'd0);

        // Forward transform.
        run_seq("fwd", 1'b0, 1'b0, 1'b0, 0, 0, dc, nw, nd);
        chk("fwd_done_cycle", 32'(dc), 32'd18);
        chk("fwd_writes", 32'(nw), 32'd12);
        chk("fwd_done_pulses", 32'(nd), 32'd1);

        // Inverse with i_inv wiggling mid-run.
        run_seq("inv_toggle", 1'b1, 1'b1, 1'b0, 0, 0, dc, nw, nd);
        chk("inv_done_cycle", 32'(dc), 32'd18);

        // Enable low for 3 cycles at stage 1, butterfly 1.
        run_seq("freeze", 1'b0, 1'b0, 1'b0, 8, 0, dc, nw, nd);
        chk("freeze_done_cycle", 32'(dc), 32'd21);
        chk("freeze_writes", 32'(nw), 32'd12);

        // Reset in the middle of stage 1.
        run_seq("abort", 1'b0, 1'b0, 1'b0, 0, 9, dc, nw, nd);
        rst = 1'b1;
        #1;
        chk("abort_outputs_zero", 32'(all_outs()), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        wr_seen = 0; blk_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (o_wr_en) wr_seen++;
            if (o_ram_block || o_busy || o_rd_en) blk_seen++;
        end
        chk("abort_no_writes", 32'(wr_seen), 32'd0);
        chk("abort_stays_idle", 32'(blk_seen), 32'd0);
        run_seq("after_abort", 1'b0, 1'b0, 1'b0, 0, 0, dc, nw, nd);
        chk("after_abort_done_cycle", 32'(dc), 32'd18);
        chk("after_abort_writes", 32'(nw), 32'd12);

        // START held high for the whole run.
        run_seq("hold", 1'b1, 1'b0, 1'b1, 0, 0, dc, nw, nd);
        chk("hold_done_pulses", 32'(nd), 32'd1);
        chk("hold_restart_from_idle", {24'd0, o_busy, o_rd_en, o_a_raddr, o_b_raddr},
            {24'd0, 1'b1, 1'b1, 3'd0, 3'd1});
        i_start = 1'b0;
        n2 = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (o_done) n2++;
        end
        chk("hold_second_run_done", 32'(n2), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_iter_seq.md
FFT_ITER_SEQ -- requirements
Module: fft_iter_seq

Interface
REQ-001 Parameter AWL, default 5, log2 of FFT points N=2^AWL, legal range 2..12.
REQ-002 Parameter BF_LAT, default 3, butterfly pipeline latency in cycles, legal range 1..8.
REQ-003 CLK  in  1  single clock, all state on rising edge.
REQ-004 RST  in  1  asynchronous, active-high reset.
REQ-005 EN  in  1  clock enable; low freezes all state and delay lines.
REQ-006 START  in  1  start request, sampled in IDLE with EN=1.
REQ-007 i_INV  in  1  inverse-transform mode, latched on accepted START.
REQ-008 o_RD_EN  out  1  read addresses valid this cycle.
REQ-009 o_A_RADDR / o_B_RADDR  out  AWL each  butterfly operand read addresses.
REQ-010 o_TW_ADDR  out  AWL-1  twiddle ROM index.
REQ-011 o_TW_CONJ  out  1  conjugate twiddle; equals latched i_INV.
REQ-012 o_WR_EN  out  1  write-back strobe.
REQ-013 o_A_WADDR / o_B_WADDR  out  AWL each  write-back addresses.
REQ-014 o_STAGE  out  ceil(log2(AWL+1))  current stage index.
REQ-015 o_BUSY  out  1  high in RUN and DRAIN.
REQ-016 o_DONE  out  1  one-cycle completion pulse.
REQ-017 o_RAM_BLOCK  out  1  external RAM port blocked; high in RUN, DRAIN, DONE.

Function
REQ-018 FSM states IDLE, RUN, DRAIN, DONE; all transitions only on cycles with EN=1.
REQ-019 IDLE->RUN on START=1; stage s=0, butterfly b=0, i_INV latched.
REQ-020 RUN: one butterfly per cycle, o_RD_EN=1, b increments 0..N/2-1; after b=N/2-1 go to DRAIN.
REQ-021 Addressing (DIT, bit-reversed input): span=2^s, pos=b mod span, grp=b>>s; A=grp*2*span+pos; B=A+span; TW=pos<<(AWL-1-s).
REQ-022 Read addresses registered: valid in the cycle o_RD_EN=1, one cycle after the counter value that produced them.
REQ-023 DRAIN: o_RD_EN=0 for exactly BF_LAT cycles (read-after-write hazard); then s<AWL-1 -> s+1, b=0, RUN; s=AWL-1 -> DONE.
REQ-024 Write path: o_WR_EN, o_A_WADDR, o_B_WADDR equal o_RD_EN, o_A_RADDR, o_B_RADDR delayed exactly BF_LAT enabled cycles.
REQ-025 Last write of each stage occurs in the final DRAIN cycle; no write occurs in IDLE or DONE.
REQ-026 DONE lasts one cycle with o_DONE=1, then IDLE; o_RAM_BLOCK drops in the IDLE cycle.
REQ-027 Run length from accepted START edge to o_DONE: AWL*(N/2+BF_LAT) cycles, then one DONE cycle.
REQ-028 START while not IDLE is ignored; START held high in DONE does not restart until IDLE.
REQ-029 START and i_INV in the same IDLE cycle: i_INV value of that cycle is used.
REQ-030 EN=0 mid-run: counters, FSM, delay line and outputs hold; resumes without loss or duplicate write.
REQ-031 Address arithmetic unsigned, width AWL, never wraps for legal b,s.

Reset
REQ-032 RST=1 forces IDLE, s=0, b=0, delay line cleared; all outputs 0 immediately, regardless of EN.
REQ-033 RST mid-run aborts the transform; no write strobe issued after RST deassertion until a new START.

Verification (AWL=3, BF_LAT=2)
REQ-034 START pulse, i_INV=0 -> stage0 reads A=0,2,4,6 B=1,3,5,7 TW=0,0,0,0; writes same pairs 2 cycles later.
REQ-035 Same run -> stage1 A=0,1,4,5 B=2,3,6,7 TW=0,2,0,2; stage2 A=0,1,2,3 B=4,5,6,7 TW=0,1,2,3; o_DONE 18 cycles after START edge.
REQ-036 i_INV=1 with START -> o_TW_CONJ=1 whole run; i_INV toggled mid-run has no effect.
REQ-037 EN low 3 cycles during stage1 b=1 -> outputs frozen; full sequence completes at 21 cycles, 12 write strobes total.
REQ-038 RST pulse during stage1 -> all outputs 0 at once, o_RAM_BLOCK=0, no writes; new START runs full clean sequence.
REQ-039 START held high through run -> exactly one o_DONE, second run begins only from IDLE.
